// File: rtl/wramp_pkg.sv
// Shared WRAMP definitions: instruction field positions, opcode and function
// encodings, FSM state codes and the immediate-extension rule.
package wramp_pkg;

  localparam int DataW   = 32;
  localparam int AddrW   = 20;
  localparam int NumRegs = 16;
  localparam int RaIdx   = 15;

  localparam int OpcodeLsb = 28;
  localparam int RdLsb     = 24;
  localparam int RsLsb     = 20;
  localparam int FuncLsb   = 16;
  localparam int RtLsb     = 0;

  typedef enum logic [3:0] {
    OP_ALU  = 4'h0, OP_ALUI = 4'h1, OP_SET  = 4'h2, OP_SETI = 4'h3,
    OP_J    = 4'h4, OP_JR   = 4'h5, OP_JAL  = 4'h6, OP_JALR = 4'h7,
    OP_LW   = 4'h8, OP_SW   = 4'h9, OP_BEQZ = 4'hA, OP_BNEZ = 4'hB
  } opcode_e;

  typedef enum logic [3:0] {
    FN_ADD  = 4'h0, FN_ADDU = 4'h1, FN_SUB  = 4'h2, FN_SUBU = 4'h3,
    FN_MULT = 4'h4, FN_MULTU = 4'h5, FN_DIV = 4'h6, FN_DIVU = 4'h7,
    FN_REM  = 4'h8, FN_REMU = 4'h9, FN_SLL  = 4'hA, FN_AND  = 4'hB,
    FN_SRL  = 4'hC, FN_OR   = 4'hD, FN_SRA  = 4'hE, FN_XOR  = 4'hF
  } alu_func_e;

  typedef enum logic [3:0] {
    SF_LT = 4'h0, SF_LTU = 4'h1, SF_GT = 4'h2, SF_GTU = 4'h3,
    SF_LE = 4'h4, SF_LEU = 4'h5, SF_GE = 4'h6, SF_GEU = 4'h7,
    SF_EQ = 4'h8, SF_EQU = 4'h9, SF_NE = 4'hA, SF_NEU = 4'hB
  } set_func_e;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_MEM   = 2'd2;

  // Only the even (signed) functions up to 9 sign-extend; everything else is zero-extended.
  function automatic logic immSignExt(input logic [3:0] func);
    return (func <= 4'd9) && !func[0];
  endfunction

endpackage

// File: rtl/wramp_alu.sv
// Combinational WRAMP ALU: arithmetic/logic results, or a 0/1 compare result
// when is_set_i selects the set-instruction interpretation of the function code.
module wramp_alu
  import wramp_pkg::*;
(
  input  logic [DataW-1:0] a_i,
  input  logic [DataW-1:0] b_i,
  input  logic [3:0]       func_i,
  input  logic             is_set_i,
  output logic [DataW-1:0] result_o
);

  logic [DataW-1:0] aluResult;
  logic             cmpResult;
  logic             lessThan;
  logic             equal;

  always_comb begin
    aluResult = '0;
    case (alu_func_e'(func_i))
      FN_ADD, FN_ADDU:   aluResult = a_i + b_i;
      FN_SUB, FN_SUBU:   aluResult = a_i - b_i;
      FN_MULT, FN_MULTU: aluResult = a_i * b_i;
      FN_DIV:  aluResult = (b_i == '0) ? '0 : DataW'($signed(a_i) / $signed(b_i));
      FN_DIVU: aluResult = (b_i == '0) ? '0 : a_i / b_i;
      FN_REM:  aluResult = (b_i == '0) ? '0 : DataW'($signed(a_i) % $signed(b_i));
      FN_REMU: aluResult = (b_i == '0) ? '0 : a_i % b_i;
      FN_SLL:  aluResult = a_i << b_i[4:0];
      FN_AND:  aluResult = a_i & b_i;
      FN_SRL:  aluResult = a_i >> b_i[4:0];
      FN_OR:   aluResult = a_i | b_i;
      FN_SRA:  aluResult = DataW'($signed(a_i) >>> b_i[4:0]);
      FN_XOR:  aluResult = a_i ^ b_i;
      default: aluResult = '0;
    endcase
  end

  // Odd set functions compare unsigned; equality tests do not care either way.
  always_comb begin
    lessThan  = func_i[0] ? (a_i < b_i) : ($signed(a_i) < $signed(b_i));
    equal     = (a_i == b_i);
    cmpResult = 1'b0;
    case (set_func_e'(func_i))
      SF_LT, SF_LTU: cmpResult = lessThan;
      SF_GT, SF_GTU: cmpResult = !lessThan && !equal;
      SF_LE, SF_LEU: cmpResult = lessThan || equal;
      SF_GE, SF_GEU: cmpResult = !lessThan;
      SF_EQ, SF_EQU: cmpResult = equal;
      SF_NE, SF_NEU: cmpResult = !equal;
      default:       cmpResult = 1'b0;
    endcase
  end

  assign result_o = is_set_i ? {{(DataW-1){1'b0}}, cmpResult} : aluResult;

endmodule

// File: rtl/wramp_cpu.sv
// Multi-cycle WRAMP core: FETCH/EXEC/MEM sequencing, register file, PC, IR and
// effective-address register around a single combinational-read memory port.
module wramp_cpu
  import wramp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_async,
  output logic [AddrW-1:0] mem_address,
  input  logic [DataW-1:0] mem_read_value,
  output logic             mem_write_en,
  output logic [DataW-1:0] mem_write_value
);

  logic [1:0]       state_q, state_d;
  logic [AddrW-1:0] pc_q, pc_d;
  logic [DataW-1:0] ir_q, ir_d;
  logic [AddrW-1:0] ea_q, ea_d;
  logic [DataW-1:0] regFile_q [NumRegs];

  logic [3:0]       opcode, rdIdx, rsIdx, rtIdx, func;
  logic [15:0]      imm16;
  logic [AddrW-1:0] off20, pcPlus1, effAddr;
  logic [DataW-1:0] rsVal, rtVal, rdVal, immExt, aluB, aluResult;
  logic             regWrEn;
  logic [3:0]       regWrIdx;
  logic [DataW-1:0] regWrData;

  assign opcode  = ir_q[OpcodeLsb +: 4];
  assign rdIdx   = ir_q[RdLsb +: 4];
  assign rsIdx   = ir_q[RsLsb +: 4];
  assign func    = ir_q[FuncLsb +: 4];
  assign rtIdx   = ir_q[RtLsb +: 4];
  assign imm16   = ir_q[15:0];
  assign off20   = ir_q[AddrW-1:0];

  // $0 is never written, so a plain array read already returns zero for it.
  assign rsVal   = regFile_q[rsIdx];
  assign rtVal   = regFile_q[rtIdx];
  assign rdVal   = regFile_q[rdIdx];

  assign immExt  = immSignExt(func) ? {{16{imm16[15]}}, imm16} : {16'b0, imm16};
  assign aluB    = opcode[0] ? immExt : rtVal;
  assign pcPlus1 = pc_q + 1'b1;
  assign effAddr = rsVal[AddrW-1:0] + off20;

  wramp_alu uAlu (
    .a_i      (rsVal),
    .b_i      (aluB),
    .func_i   (func),
    .is_set_i (opcode[1]),
    .result_o (aluResult)
  );

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    ir_d            = ir_q;
    ea_d            = ea_q;
    regWrEn         = 1'b0;
    regWrIdx        = rdIdx;
    regWrData       = aluResult;
    mem_address     = pc_q;
    mem_write_en    = 1'b0;
    mem_write_value = '0;
    case (state_q)
      ST_FETCH: begin
        ir_d    = mem_read_value;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pcPlus1;
        case (opcode_e'(opcode))
          OP_ALU, OP_ALUI, OP_SET, OP_SETI: regWrEn = 1'b1;
          OP_J:  pc_d = effAddr;
          OP_JR: pc_d = rsVal[AddrW-1:0];
          OP_JAL, OP_JALR: begin
            pc_d      = (opcode_e'(opcode) == OP_JAL) ? effAddr : rsVal[AddrW-1:0];
            regWrEn   = 1'b1;
            regWrIdx  = 4'(RaIdx);
            regWrData = {{(DataW-AddrW){1'b0}}, pcPlus1};
          end
          OP_LW, OP_SW: begin
            ea_d    = effAddr;
            pc_d    = pc_q;
            state_d = ST_MEM;
          end
          OP_BEQZ: if (rsVal == '0) pc_d = pcPlus1 + off20;
          OP_BNEZ: if (rsVal != '0) pc_d = pcPlus1 + off20;
          default: ;
        endcase
      end
      ST_MEM: begin
        mem_address = ea_q;
        pc_d        = pcPlus1;
        state_d     = ST_FETCH;
        if (opcode_e'(opcode) == OP_SW) begin
          mem_write_en    = 1'b1;
          mem_write_value = rdVal;
        end else begin
          regWrEn   = 1'b1;
          regWrData = mem_read_value;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_async) begin
    if (!rst_async) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      ea_q    <= '0;
      for (int i = 0; i < NumRegs; i++) regFile_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ea_q    <= ea_d;
      if (regWrEn && (regWrIdx != 4'd0)) regFile_q[regWrIdx] <= regWrData;
    end
  end

endmodule

// File: tb/tb_wramp_cpu.sv
// Scoreboard bench for wramp_cpu: small WRAMP programs run from a behavioural
// memory, and every store the core issues is matched against queued expectations.
module tb_wramp_cpu;

  logic        clk = 1'b0;
  logic        rst_async = 1'b1;
  logic [19:0] mem_address;
  logic [31:0] mem_read_value;
  logic        mem_write_en;
  logic [31:0] mem_write_value;

  logic [31:0] mem [0:1048575];

  typedef struct {
    logic [19:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t sbQ[$];
  int  checkCount = 0;
  int  passCount  = 0;
  int  loadAddr   = 0;

  wramp_cpu dut (
    .clk             (clk),
    .rst_async       (rst_async),
    .mem_address     (mem_address),
    .mem_read_value  (mem_read_value),
    .mem_write_en    (mem_write_en),
    .mem_write_value (mem_write_value)
  );

  always #5 clk = ~clk;

  assign mem_read_value = mem[mem_address];

  always @(posedge clk) begin
    if (mem_write_en) mem[mem_address] = mem_write_value;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  // Every store the core presents must match the oldest outstanding expectation.
  always @(negedge clk) begin
    wr_t e;
    if (mem_write_en) begin
      if (sbQ.size() == 0) begin
        checkOutput("spuriousWrite", {31'b0, mem_write_en}, 32'd0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("writeAddr", {12'b0, mem_address}, {12'b0, e.addr});
        checkOutput("writeData", mem_write_value, e.data);
      end
    end
  end

  function automatic logic [31:0] encR(input int op, input int rd, input int rs, input int fn, input int rt);
    return {op[3:0], rd[3:0], rs[3:0], fn[3:0], 12'b0, rt[3:0]};
  endfunction

  function automatic logic [31:0] encI(input int op, input int rd, input int rs, input int fn, input int imm);
    return {op[3:0], rd[3:0], rs[3:0], fn[3:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] encJ(input int op, input int rd, input int rs, input int off);
    return {op[3:0], rd[3:0], rs[3:0], off[19:0]};
  endfunction

  task automatic emit(input logic [31:0] w);
    mem[loadAddr] = w;
    loadAddr++;
  endtask

  task automatic expectWrite(input int addr, input logic [31:0] data);
    wr_t e;
    e.addr = addr[19:0];
    e.data = data;
    sbQ.push_back(e);
  endtask

  task automatic holdReset();
    @(negedge clk);
    rst_async = 1'b0;
    sbQ.delete();
    for (int a = 0; a < 1024; a++) mem[a] = 32'd0;
    mem[20'hfffff] = 32'd0;
    loadAddr = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic drainScoreboard(input string name, input int budget);
    for (int c = 0; c < budget && sbQ.size() > 0; c++) begin
      @(negedge clk);
      #1;
    end
    checkOutput({name, "Pending"}, 32'(sbQ.size()), 32'd0);
    repeat (20) @(negedge clk);
  endtask

  task automatic applyStimulus(input string name, input int budget);
    rst_async = 1'b1;
    drainScoreboard(name, budget);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [19:0] addrSeq [6];
    logic        seen;

    #1 rst_async = 1'b0;

    // Reset behaviour plus the summing program.
    holdReset();
    checkOutput("resetAddr", {12'b0, mem_address}, 32'd0);
    checkOutput("resetWriteEn", {31'b0, mem_write_en}, 32'd0);
    checkOutput("resetWriteValue", mem_write_value, 32'd0);
    emit(encI(1, 1, 0, 0, 10));
    emit(encR(0, 2, 0, 'hB, 0));
    emit(encJ(8, 3, 1, 0));
    emit(encR(0, 2, 2, 0, 3));
    emit(encI(1, 1, 1, 0, 1));
    emit(encI(1, 4, 1, 2, 18));
    emit(encJ('hB, 0, 4, -5));
    emit(encJ(9, 2, 0, 'hff));
    emit(encI(1, 15, 0, 'hD, 'hdead));
    emit(encJ(9, 15, 0, 'hfffff));
    emit(32'h10000000); emit(32'h02000000); emit(32'h00300000); emit(32'h00040000);
    emit(32'h00005000); emit(32'h00000600); emit(32'h00000070); emit(32'h00000008);
    expectWrite('h000ff, 32'h12345678);
    expectWrite('hfffff, 32'h0000dead);
    rst_async = 1'b1;
    checkOutput("firstFetch", {12'b0, mem_address}, 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("secondFetch", {12'b0, mem_address}, 32'd1);
    drainScoreboard("sum", 1000);

    // addi occupies 2 cycles, lw 3 (FETCH, EXEC, MEM at the effective address).
    holdReset();
    emit(encI(1, 1, 0, 0, 3));
    emit(encJ(8, 2, 0, 5));
    emit(encJ(9, 2, 0, 'h30));
    emit(encJ(4, 0, 0, 3));
    mem[5] = 32'hCAFEF00D;
    expectWrite('h30, 32'hCAFEF00D);
    addrSeq = '{20'd0, 20'd0, 20'd1, 20'd1, 20'd5, 20'd2};
    rst_async = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput($sformatf("cycleAddr%0d", i), {12'b0, mem_address}, {12'b0, addrSeq[i]});
    end
    drainScoreboard("cycle", 100);

    holdReset();
    emit(encI(1, 0, 0, 0, 5));
    emit(encJ(9, 0, 0, 'h20));
    emit(encJ(4, 0, 0, 2));
    mem['h20] = 32'hFFFFFFFF;
    expectWrite('h20, 32'd0);
    applyStimulus("zeroReg", 100);

    // jal/jr round trip, then beqz skips the two instructions that would store 0x111.
    holdReset();
    emit(encJ(6, 0, 0, 'h40));
    emit(encJ('hA, 0, 0, 2));
    emit(encI(1, 5, 0, 0, 'h111));
    emit(encJ(9, 5, 0, 'h52));
    emit(encI(1, 6, 0, 0, 'h77));
    emit(encJ(9, 6, 0, 'h53));
    emit(encJ(4, 0, 0, 6));
    loadAddr = 'h40;
    emit(encJ(9, 15, 0, 'h50));
    emit(encJ(5, 0, 15, 0));
    expectWrite('h50, 32'd1);
    expectWrite('h53, 32'h77);
    applyStimulus("jumps", 200);

    holdReset();
    emit(encI(1, 1, 0, 2, 1));        emit(encJ(9, 1, 0, 'h60));
    emit(encI(1, 2, 1, 'hE, 4));      emit(encJ(9, 2, 0, 'h61));
    emit(encI(1, 3, 1, 'hC, 4));      emit(encJ(9, 3, 0, 'h62));
    emit(encI(1, 4, 0, 0, 7));
    emit(encR(0, 4, 1, 6, 0));        emit(encJ(9, 4, 0, 'h63));
    emit(encR(2, 5, 1, 0, 0));        emit(encJ(9, 5, 0, 'h64));
    emit(encI(1, 6, 0, 0, 9));
    emit(encR(2, 6, 1, 1, 0));        emit(encJ(9, 6, 0, 'h65));
    emit(encR(0, 7, 1, 4, 1));        emit(encJ(9, 7, 0, 'h66));
    emit(encI(1, 8, 0, 1, 'hffff));   emit(encJ(9, 8, 0, 'h67));
    emit(encI(1, 9, 1, 'hF, 'h00ff)); emit(encJ(9, 9, 0, 'h68));
    emit(encJ(4, 0, 0, 20));
    expectWrite('h60, 32'hffffffff);
    expectWrite('h61, 32'hffffffff);
    expectWrite('h62, 32'h0fffffff);
    expectWrite('h63, 32'h00000000);
    expectWrite('h64, 32'h00000001);
    expectWrite('h65, 32'h00000000);
    expectWrite('h66, 32'h00000001);
    expectWrite('h67, 32'h0000ffff);
    expectWrite('h68, 32'hffffff00);
    applyStimulus("arith", 400);

    // Reset asserted while a store is on the bus must suppress the write.
    holdReset();
    emit(encI(1, 1, 0, 0, 'h55));
    emit(encJ(9, 1, 0, 'h70));
    emit(encJ(4, 0, 0, 2));
    expectWrite('h70, 32'h55);
    rst_async = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      #1;
      seen = mem_write_en;
    end
    checkOutput("abortStoreSeen", {31'b0, seen}, 32'd1);
    rst_async = 1'b0;
    #1;
    checkOutput("abortWriteEn", {31'b0, mem_write_en}, 32'd0);
    checkOutput("abortAddr", {12'b0, mem_address}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("abortMem", mem['h70], 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/wramp_cpu.md
# wramp_cpu

Multi-cycle, non-pipelined 32-bit WRAMP processor core with a single unified word-addressed memory port. Fetches, decodes and executes the WRAMP integer subset (ALU, set, jump, load/store, branch) from a combinational-read / synchronous-write memory. The simulation harness wraps it, and it is the top of the CPU hierarchy.

## Interface
- No parameters. Fixed widths: data 32 bits, address/PC 20 bits, 16 registers.
- `clk` in 1: single clock, all state on rising edge.
- `rst_async` in 1: one clock; reset is asynchronous and active-low.
- `mem_address` out 20: word address. PC during fetch, effective address during memory access.
- `mem_read_value` in 32: combinational read data for `mem_address` (same-cycle).
- `mem_write_en` out 1: memory writes `mem_write_value` at `mem_address` on the next rising edge.
- `mem_write_value` out 32: store data. Value is 0 when `mem_write_en`=0.

## Operation
- Instruction fields: [31:28] opcode, [27:24] Rd, [23:20] Rs, [19:16] func, [3:0] Rt, [15:0] imm16, [19:0] off20.
- Register file: 16×32. `$0` reads 0 and writes to it are discarded. `$15` is `$ra`.
- Opcode 0: Rd = Rs op Rt. Opcode 1: Rd = Rs op imm.
  - func codes: 0 add, 1 addu, 2 sub, 3 subu, 4 mult, 5 multu, 6 div, 7 divu, 8 rem, 9 remu, A sll, B and, C srl, D or, E sra, F xor.
  - Products keep the low 32 bits.
  - div or rem by zero → result 0.
  - Shifts use operand[4:0].
  - Immediate is sign-extended for signed ops. It is zero-extended for unsigned ops (odd func ≤9) and for and/or/xor/shifts.
  - No overflow traps.
- Opcode 2/3 (set, R/I forms): Rd = 1 if the compare holds, else 0.
  - func: 0 lt, 1 ltu, 2 gt, 3 gtu, 4 le, 5 leu, 6 ge, 7 geu, 8 eq, 9 equ, A ne, B neu.
  - Extension rule is the same as above.
- Opcode 4 `j`: PC = Rs + sext(off20). 5 `jr`: PC = Rs[19:0]. 6 `jal` and 7 `jalr`: same as 4 and 5, plus `$ra` = PC+1.
- Opcode 8 `lw`: Rd = mem[Rs + sext(off20)]. 9 `sw`: mem[Rs + sext(off20)] = Rd.
- Opcode A `beqz`: if Rs == 0, PC = PC+1+sext(off20). B `bnez`: if Rs != 0, same update. Otherwise PC = PC+1.
- Opcodes C–F: no-op, PC = PC+1.
- All address arithmetic is modulo 2^20.

## Timing
- FSM states are FETCH, EXEC, MEM.
  - FETCH: `mem_address` = PC. IR ← `mem_read_value`. Go to EXEC.
  - EXEC: decode and ALU. Register writeback and PC update for all non-memory ops, then go to FETCH. `lw`/`sw` latch the effective address and go to MEM.
  - MEM: `mem_address` = EA.
    - `lw`: Rd ← `mem_read_value`.
    - `sw`: `mem_write_en`=1, `mem_write_value`=Rd.
    - PC ← PC+1, then go to FETCH.
- Latency: 2 cycles for non-memory instructions, 3 for lw/sw. One `mem_write_en` pulse per store.
- Reset (`rst_async` low, immediate):
  - PC=0, state=FETCH, IR=0, all registers 0.
  - `mem_write_en`=0, `mem_write_value`=0, `mem_address`=0.
- The first fetch occurs on the first rising edge after release. Reset mid-store aborts the write.

## Structure
- `wramp_pkg`: opcode enum, ALU/set func enums, FSM state enum, field-position constants.
- Sub-module `wramp_alu`: combinational, inputs a, b, func, is_set. Output 32-bit result.
- The core holds the FSM, register file, IR, PC, EA and decode.

## Test plan
- Reset held low 2 cycles then released → `mem_address`=0 and `mem_write_en`=0 during reset. First fetch at address 0.
- Sum program, 10 instructions: `addi $1,$0,10`; `and $2,$0,$0`; a loop of `lw $3,0($1)`, `add $2,$2,$3`, `addi $1,$1,1`, `subi $4,$1,18`, `bnez $4,-5`; `sw $2,0xff($0)`; `ori $15,$0,0xdead`; `sw $15,0xfffff($0)`. Data words 0x10000000, 0x02000000 … 0x00000008 sit at 10–17.
  - Required: a write of 0x12345678 to 0x000ff, then 0x0000dead to 0xfffff, completing within 1000 cycles.
- Cycle count: an `addi` takes exactly 2 cycles and an `lw` exactly 3, checked via `mem_address` sequence.
- Writes to `$0` (`addi $0,$0,5`, then `sw $0,0x20($0)`) → mem[0x20]=0.
- Jumps: `jal` to 0x40 → `$ra`=PC+1. `jr $15` returns. Then `beqz $0,+2` skips 2 instructions.
- Arithmetic edges:
  - `subi $1,$0,1` → 0xffffffff.
  - `srai $2,$1,4` → 0xffffffff.
  - `srli` → 0x0fffffff.
  - `div` by 0 → 0.
  - `slt` with −1 < 0 → 1.
  - `sltu` → 0.
